// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU's memory-stage data port.
// Accepts one load/store at a time, inserts WAIT_STATES wait cycles,
// performs the array access and returns a single-cycle response.
// While a request is outstanding, stall_o holds the pipeline.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_size_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = IDX_W + 2;

  // Counter preload; WAIT lasts WAIT_LOAD + 1 cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Load/store funct3 encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } stateT;

  stateT                 state;
  logic [3:0]            waitCnt;
  logic [OFF_W-1:0]      addrQ;
  logic [2:0]            sizeQ;
  logic                  weQ;
  logic [DATA_WIDTH-1:0] wdataQ;

  logic                  reqErr;
  logic [IDX_W-1:0]      wordIdx;
  logic [1:0]            byteOff;
  logic [DATA_WIDTH-1:0] memWord;
  logic [7:0]            loadByte;
  logic [15:0]           loadHalf;
  logic [DATA_WIDTH-1:0] loadData;
  logic [3:0]            byteEn;
  logic [DATA_WIDTH-1:0] storeWord;
  logic [DATA_WIDTH-1:0] mergedWord;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address bits above the array span alias and are deliberately dropped
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr_i[DATA_WIDTH-1:OFF_W];

  assign req_ready_o = (state == StIdle);
  assign stall_o     = (state != StIdle) || req_valid_i;

  assign wordIdx = addrQ[OFF_W-1:2];
  assign byteOff = addrQ[1:0];
  assign memWord = mem[wordIdx];

  // Classify the incoming request: misaligned halves/words and reserved sizes
  always_comb begin
    reqErr = 1'b0;
    case (req_size_i)
      SZ_B, SZ_BU: reqErr = 1'b0;
      SZ_H, SZ_HU: reqErr = addr_i[0];
      SZ_W:        reqErr = |addr_i[1:0];
      default:     reqErr = 1'b1;
    endcase
  end

  // Select the addressed byte/half of the stored word and extend it
  always_comb begin
    loadByte = memWord[{byteOff, 3'b000} +: 8];
    loadHalf = byteOff[1] ? memWord[31:16] : memWord[15:0];
    case (sizeQ)
      SZ_B:    loadData = {{(DATA_WIDTH-8){loadByte[7]}}, loadByte};
      SZ_BU:   loadData = {{(DATA_WIDTH-8){1'b0}}, loadByte};
      SZ_H:    loadData = {{(DATA_WIDTH-16){loadHalf[15]}}, loadHalf};
      SZ_HU:   loadData = {{(DATA_WIDTH-16){1'b0}}, loadHalf};
      default: loadData = memWord;
    endcase
  end

  // Replicate store data across lanes and merge only the enabled bytes
  always_comb begin
    case (sizeQ)
      SZ_B: begin
        byteEn    = 4'b0001 << byteOff;
        storeWord = {4{wdataQ[7:0]}};
      end
      SZ_H: begin
        byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{wdataQ[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeWord = wdataQ;
      end
    endcase
    mergedWord = memWord;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        mergedWord[8*i +: 8] = storeWord[8*i +: 8];
      end
    end
  end

  // Array write on the ACCESS->RESP edge; contents survive reset
  always_ff @(posedge clk) begin
    if (state == StAccess && weQ) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      waitCnt      <= '0;
      addrQ        <= '0;
      sizeQ        <= '0;
      weQ          <= 1'b0;
      wdataQ       <= '0;
      resp_valid_o <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid_i) begin
            addrQ  <= addr_i[OFF_W-1:0];
            sizeQ  <= req_size_i;
            weQ    <= req_we_i;
            wdataQ <= wdata_i;
            if (reqErr) begin
              state        <= StResp;
              resp_valid_o <= 1'b1;
              err_o        <= 1'b1;
              rdata_o      <= '0;
            end else if (WAIT_STATES > 0) begin
              waitCnt <= WAIT_LOAD;
              state   <= StWait;
            end else begin
              state <= StAccess;
            end
          end
        end
        StWait: begin
          if (waitCnt == '0) begin
            state <= StAccess;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        StAccess: begin
          state        <= StResp;
          resp_valid_o <= 1'b1;
          err_o        <= 1'b0;
          rdata_o      <= weQ ? '0 : loadData;
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_STATES 2 and 0),
// directed steps followed by randomized traffic against a byte-array model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        validA, validB, we;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        readyA, respA, errA, stallA;
  logic        readyB, respB, errB, stallB;
  logic [31:0] rdataA, rdataB;

  data_mem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dutA (
    .clk(clk), .rst(rst), .req_valid_i(validA), .req_we_i(we), .req_size_i(size),
    .addr_i(addr), .wdata_i(wdata), .req_ready_o(readyA), .resp_valid_o(respA),
    .rdata_o(rdataA), .err_o(errA), .stall_o(stallA)
  );

  data_mem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dutB (
    .clk(clk), .rst(rst), .req_valid_i(validB), .req_we_i(we), .req_size_i(size),
    .addr_i(addr), .wdata_i(wdata), .req_ready_o(readyB), .resp_valid_o(respB),
    .rdata_o(rdataB), .err_o(errB), .stall_o(stallB)
  );

  int          sel = 0;
  logic        readyS, respS, errS, stallS;
  logic [31:0] rdataS;

  // Route the selected instance's outputs to the checkers
  always_comb begin
    if (sel == 1) begin
      readyS = readyB; respS = respB; errS = errB; stallS = stallB; rdataS = rdataB;
    end else begin
      readyS = readyA; respS = respA; errS = errA; stallS = stallA; rdataS = rdataA;
    end
  end

  int passCnt = 0;
  int totalCnt = 0;

  // Byte-addressed reference memory per instance, indexed modulo 4096 bytes
  logic [7:0] mb [2][4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s dut%0d observed=%b expected=%b", tag, sel, obs, exp);
  endtask

  function automatic logic mErr(input logic [2:0] sz, input logic [31:0] a);
    case (sz)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mLoad(input int s, input logic [2:0] sz, input logic [31:0] a);
    int o;
    int x;
    logic [31:0] v;
    o = int'(a % 4096);
    v = '0;
    case (sz)
      3'd0: begin x = $signed(mb[s][o]); v = x; end
      3'd4: v = {24'd0, mb[s][o]};
      3'd1: begin x = $signed({mb[s][o+1], mb[s][o]}); v = x; end
      3'd5: v = {16'd0, mb[s][o+1], mb[s][o]};
      default: v = {mb[s][o+3], mb[s][o+2], mb[s][o+1], mb[s][o]};
    endcase
    return v;
  endfunction

  task automatic mStore(input int s, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    int o;
    int n;
    o = int'(a % 4096);
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[s][o+i] = 8'(d >> (8*i));
  endtask

  // One complete request with latency, stall, ready and response checks
  task automatic doReq(input int s, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] obsData, output logic obsErr);
    logic        eErr;
    logic [31:0] eData;
    int          eLat;
    int          n;
    eErr  = mErr(sz, a);
    eData = (eErr || w) ? 32'd0 : mLoad(s, sz, a);
    eLat  = eErr ? 1 : ((s == 0) ? 2 : 0) + 2;
    sel   = s;
    @(negedge clk);
    we = w; size = sz; addr = a; wdata = d;
    if (s == 0) validA = 1'b1; else validB = 1'b1;
    #1;
    chk1("ready_idle", readyS, 1'b1);
    chk1("stall_req", stallS, 1'b1);
    @(posedge clk);
    @(negedge clk);
    validA = 1'b0; validB = 1'b0;
    we = 1'($urandom); size = 3'($urandom); addr = $urandom; wdata = $urandom;
    n = 1;
    while (respS !== 1'b1 && n < 40) begin
      chk1("stall_busy", stallS, 1'b1);
      chk1("ready_busy", readyS, 1'b0);
      @(negedge clk);
      n++;
    end
    chk("latency", n, eLat);
    chk1("stall_resp", stallS, 1'b1);
    chk1("err", errS, eErr);
    chk("rdata", rdataS, eData);
    obsData = rdataS;
    obsErr  = errS;
    if (!eErr && w) mStore(s, sz, a, d);
    @(negedge clk);
    chk1("resp_single", respS, 1'b0);
    chk1("ready_back", readyS, 1'b1);
    chk1("stall_idle", stallS, 1'b0);
    chk("rdata_hold", rdataS, eData);
    chk1("err_hold", errS, eErr);
  endtask

  // Word loads with req_valid held high; checks spacing and one response per accept
  task automatic b2b(input int s);
    int          acc[$];
    int          rsp[$];
    logic [31:0] expQ[$];
    logic [31:0] a;
    int          ws;
    ws  = (s == 0) ? 2 : 0;
    sel = s;
    @(negedge clk);
    we = 1'b0; size = 3'd2;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (respS === 1'b1) begin
        rsp.push_back(cyc);
        if (expQ.size() > 0) chk("b2b_rdata", rdataS, expQ.pop_front());
        else chk("b2b_extra_resp", expQ.size(), 1);
      end
      if (readyS === 1'b1 && acc.size() < 3) begin
        a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) * 4);
        addr = a;
        expQ.push_back(mLoad(s, 3'd2, a));
        acc.push_back(cyc);
        if (s == 0) validA = 1'b1; else validB = 1'b1;
      end else if (readyS === 1'b1) begin
        validA = 1'b0; validB = 1'b0;
      end
      @(negedge clk);
    end
    validA = 1'b0; validB = 1'b0;
    chk("b2b_accepts", acc.size(), 3);
    chk("b2b_resps", rsp.size(), 3);
    if (acc.size() == 3 && rsp.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_latency", rsp[i] - acc[i], ws + 2);
      for (int i = 0; i < 2; i++) chk("b2b_spacing", acc[i+1] - acc[i], ws + 3);
    end
  endtask

  logic [31:0] d;
  logic        e;
  int          seen;
  logic [2:0]  sizes [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd2};
  logic [2:0]  sz;
  logic [31:0] ra;

  initial begin
    rst = 1'b0; validA = 1'b0; validB = 1'b0; we = 1'b0; size = '0; addr = '0; wdata = '0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk1("rst_ready", readyS, 1'b1);
      chk1("rst_resp", respS, 1'b0);
      chk("rst_rdata", rdataS, 32'd0);
      chk1("rst_err", errS, 1'b0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed steps on the two-wait-state instance
    doReq(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, d, e);
    chk1("SW_err", e, 1'b0);
    doReq(0, 1'b0, 3'd2, 32'h10, 32'h0, d, e); chk("LW_0x10", d, 32'hDEADBEEF);
    doReq(0, 1'b0, 3'd0, 32'h13, 32'h0, d, e); chk("LB_0x13", d, 32'hFFFFFFDE);
    doReq(0, 1'b0, 3'd4, 32'h13, 32'h0, d, e); chk("LBU_0x13", d, 32'h000000DE);
    doReq(0, 1'b0, 3'd1, 32'h10, 32'h0, d, e); chk("LH_0x10", d, 32'hFFFFBEEF);
    doReq(0, 1'b0, 3'd5, 32'h12, 32'h0, d, e); chk("LHU_0x12", d, 32'h0000DEAD);
    doReq(0, 1'b1, 3'd0, 32'h11, 32'h000000AA, d, e);
    doReq(0, 1'b0, 3'd2, 32'h10, 32'h0, d, e); chk("LW_after_SB", d, 32'hDEADAAEF);
    doReq(0, 1'b1, 3'd1, 32'h12, 32'h00001234, d, e); chk1("SH_0x12_err", e, 1'b0);
    doReq(0, 1'b0, 3'd2, 32'h10, 32'h0, d, e); chk("LW_after_SH", d, 32'h1234AAEF);
    doReq(0, 1'b1, 3'd1, 32'h11, 32'h00005555, d, e); chk1("SH_0x11_err", e, 1'b1);
    doReq(0, 1'b0, 3'd2, 32'h10, 32'h0, d, e); chk("LW_after_badSH", d, 32'h1234AAEF);
    doReq(0, 1'b0, 3'd3, 32'h10, 32'h0, d, e); chk1("size011_err", e, 1'b1);
    doReq(0, 1'b0, 3'd2, 32'h4012, 32'h0, d, e); chk1("LW_misaligned_err", e, 1'b1);
    doReq(0, 1'b0, 3'd2, 32'hABCD_F010, 32'h0, d, e); chk("LW_alias", d, 32'h1234AAEF);

    // Reset in the middle of a store's wait period
    doReq(0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, d, e);
    sel = 0;
    @(negedge clk);
    we = 1'b1; size = 3'd2; addr = 32'h20; wdata = 32'h12345678; validA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validA = 1'b0;
    chk1("in_wait_ready", readyS, 1'b0);
    rst = 1'b0;
    #1;
    chk1("midrst_ready", readyS, 1'b1);
    chk1("midrst_resp", respS, 1'b0);
    chk("midrst_rdata", rdataS, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (respS === 1'b1) seen++;
    end
    chk("midrst_no_resp", seen, 0);
    doReq(0, 1'b0, 3'd2, 32'h20, 32'h0, d, e); chk("LW_after_rst", d, 32'hCAFEF00D);

    // Zero-wait-state instance
    doReq(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, d, e);
    doReq(1, 1'b0, 3'd2, 32'h10, 32'h0, d, e); chk("B_LW_0x10", d, 32'hDEADBEEF);
    doReq(1, 1'b0, 3'd0, 32'h13, 32'h0, d, e); chk("B_LB_0x13", d, 32'hFFFFFFDE);
    doReq(1, 1'b1, 3'd1, 32'h11, 32'h0, d, e); chk1("B_SH_err", e, 1'b1);

    // Fill a 64-byte region on both instances, then back-to-back and random traffic
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) doReq(s, 1'b1, 3'd2, 32'(w * 4), $urandom, d, e);
    end
    b2b(0);
    b2b(1);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 40; k++) begin
        sz = sizes[$urandom_range(0, 9)];
        ra = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 60));
        doReq(s, 1'($urandom), sz, ra, $urandom, d, e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
